// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the system-bus arbiter and related arbiters.
//   - Requester id constants (bit index into bus_req/bus_ack)
//   - Arbiter state encoding
//   - Default watchdog timeout
package bus_arbiter_rr_pkg;

   localparam int BUS_ICACHE      = 0;
   localparam int BUS_DCACHE      = 1;
   localparam int BUS_NREQ        = 8;
   localparam int BUS_TIMEOUT_DEF = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of i_req at or above i_ptr, wrapping.
// Purely combinational; shared by the bus and writeback/cp arbiters.
// Ports:
//   i_req  N-bit request vector
//   i_ptr  priority pointer (index searched first)
//   o_vld  any request present
//   o_idx  picked index (0 when !o_vld)
//   o_oh   one-hot of picked index (0 when !o_vld)
module rr_pick #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_vld,
   output logic [IW-1:0] o_idx,
   output logic [N-1:0]  o_oh
);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;

   // Rotating the doubled vector right by ptr puts req[ptr] at bit 0, so
   // a plain lowest-bit priority encoder gives the offset from ptr.
   always_comb begin
      int off;
      int sum;
      w_dbl = {i_req, i_req} >> i_ptr;
      w_rot = w_dbl[N-1:0];
      off   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) off = i;
      end
      sum = int'(i_ptr) + off;
      if (sum >= N) sum = sum - N;
      o_vld = |w_rot;
      o_idx = o_vld ? IW'(sum) : '0;
      o_oh  = o_vld ? (N'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared OR-combined system bus.
// Grants are registered one-hot and locked until the owner drops its
// request; a dead (all-zero) cycle always separates two owners. A
// watchdog evicts an owner that sees no bus_ready for TIMEOUT cycles.
// Ports:
//   clk, Nrst      clock, async active-low reset
//   bus_req        per-requester level request
//   bus_ready      slave beat-complete
//   bus_ack        one-hot grant (0 when idle)
//   bus_busy       OR of bus_ack
//   bus_owner      current/last grantee id
//   timeout_err    one-cycle eviction pulse
//   timeout_id     id of last evicted requester
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int NREQ    = BUS_NREQ,
   parameter int TIMEOUT = BUS_TIMEOUT_DEF,
   parameter int IDW     = 3
) (
   input  logic            clk,
   input  logic            Nrst,
   input  logic [NREQ-1:0] bus_req,
   input  logic            bus_ready,
   output logic [NREQ-1:0] bus_ack,
   output logic            bus_busy,
   output logic [IDW-1:0]  bus_owner,
   output logic            timeout_err,
   output logic [IDW-1:0]  timeout_id
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t      r_state;
   logic [NREQ-1:0] r_ack;
   logic [NREQ-1:0] r_mask;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_owner;
   logic [CW-1:0]   r_cnt;
   logic            r_tmo_err;
   logic [IDW-1:0]  r_tmo_id;

   logic            w_pick_vld;
   logic [IDW-1:0]  w_pick_idx;
   logic [NREQ-1:0] w_pick_oh;
   logic            w_own_req;
   logic            w_evict;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [NREQ-1:0] w_mask_nxt;

   rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
      .i_req (bus_req & ~r_mask),
      .i_ptr (r_ptr),
      .o_vld (w_pick_vld),
      .o_idx (w_pick_idx),
      .o_oh  (w_pick_oh)
   );

   assign w_own_req = |(bus_req & r_ack);

   // A release (owner req low) or a ready beat on this edge both take
   // precedence over eviction.
   assign w_evict = (TIMEOUT > 0) && (r_state == GRANT) && w_own_req &&
                    !bus_ready && (r_cnt == CNT_LAST);

   assign w_ptr_nxt = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

   // Mask bits fall as soon as the requester lets go of its request.
   assign w_mask_nxt = (r_mask & bus_req) | (w_evict ? r_ack : '0);

   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         r_state   <= IDLE;
         r_ack     <= '0;
         r_mask    <= '0;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_cnt     <= '0;
         r_tmo_err <= 1'b0;
         r_tmo_id  <= '0;
      end else begin
         r_tmo_err <= 1'b0;
         r_mask    <= w_mask_nxt;
         case (r_state)
            IDLE: begin
               if (w_pick_vld) begin
                  r_ack   <= w_pick_oh;
                  r_owner <= w_pick_idx;
                  r_cnt   <= '0;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (!w_own_req) begin
                  r_ack   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= IDLE;
               end else if (w_evict) begin
                  r_ack     <= '0;
                  r_ptr     <= w_ptr_nxt;
                  r_state   <= IDLE;
                  r_tmo_err <= 1'b1;
                  r_tmo_id  <= r_owner;
               end else if (bus_ready) begin
                  r_cnt <= '0;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus_ack     = r_ack;
   assign bus_busy    = |r_ack;
   assign bus_owner   = r_owner;
   assign timeout_err = r_tmo_err;
   assign timeout_id  = r_tmo_id;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (NREQ=8, TIMEOUT=16). Each step
// drives inputs, queues the expected post-edge outputs, then checks them.
module tb_bus_arbiter_rr;

   logic       clk = 1'b0;
   logic       Nrst;
   logic [7:0] bus_req;
   logic       bus_ready;
   logic [7:0] bus_ack;
   logic       bus_busy;
   logic [2:0] bus_owner;
   logic       timeout_err;
   logic [2:0] timeout_id;

   typedef struct packed {
      logic [7:0] ack;
      logic [2:0] owner;
      logic       err;
      logic [2:0] tid;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [2:0] m_owner = '0;
   logic [2:0] m_tid   = '0;

   bus_arbiter_rr #(.NREQ(8), .TIMEOUT(16), .IDW(3)) dut (
      .clk         (clk),
      .Nrst        (Nrst),
      .bus_req     (bus_req),
      .bus_ready   (bus_ready),
      .bus_ack     (bus_ack),
      .bus_busy    (bus_busy),
      .bus_owner   (bus_owner),
      .timeout_err (timeout_err),
      .timeout_id  (timeout_id)
   );

   always #5 clk = ~clk;

   task automatic compare();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (bus_ack === e.ack) else begin
         errors++; $error("FAIL %s ack got %h want %h", t, bus_ack, e.ack);
      end
      checks++;
      assert (bus_busy === (|e.ack)) else begin
         errors++; $error("FAIL %s busy got %b want %b", t, bus_busy, |e.ack);
      end
      checks++;
      assert (bus_owner === e.owner) else begin
         errors++; $error("FAIL %s owner got %0d want %0d", t, bus_owner, e.owner);
      end
      checks++;
      assert (timeout_err === e.err) else begin
         errors++; $error("FAIL %s err got %b want %b", t, timeout_err, e.err);
      end
      checks++;
      assert (timeout_id === e.tid) else begin
         errors++; $error("FAIL %s tid got %0d want %0d", t, timeout_id, e.tid);
      end
   endtask

   // Drive one cycle of inputs; expected outputs after the next edge.
   task automatic step(input logic [7:0] req, input logic rdy,
                       input logic [7:0] ack, input logic err, input string tag);
      bus_req   = req;
      bus_ready = rdy;
      for (int i = 0; i < 8; i++) if (ack[i]) m_owner = 3'(i);
      if (err) m_tid = m_owner;
      exp_q.push_back('{ack: ack, owner: m_owner, err: err, tid: m_tid});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      Nrst = 1'b0; bus_req = '0; bus_ready = 1'b0;
      #2;
      exp_q.push_back('0); tag_q.push_back("reset");
      compare();
      #10 Nrst = 1'b1;  // released between edges

      // Single requester, ack 4 cycles then drop
      for (int k = 0; k < 4; k++) step(8'h00, 1, 8'h00, 0, "idle");
      step(8'h01, 1, 8'h01, 0, "single_grant");
      for (int k = 0; k < 3; k++) step(8'h01, 1, 8'h01, 0, "single_hold");
      step(8'h00, 1, 8'h00, 0, "single_drop");

      // Contention: pointer is 1, so rotation 1,0,1,0 with a dead cycle
      for (int g = 0; g < 4; g++) begin
         logic [7:0] oh;
         oh = (g % 2 == 0) ? 8'h02 : 8'h01;
         step(8'h03, 1, oh, 0, "rot_grant");
         step(8'h03, 1, oh, 0, "rot_hold");
         step(8'h03, 1, oh, 0, "rot_hold");
         step(8'h03 & ~oh, 1, 8'h00, 0, "rot_gap");
      end

      // Wrap-around: serve 6, then 7 before 0
      step(8'h40, 1, 8'h40, 0, "wrap_g6");
      step(8'h00, 1, 8'h00, 0, "wrap_r6");
      step(8'h81, 1, 8'h80, 0, "wrap_g7");
      step(8'h81, 1, 8'h80, 0, "wrap_h7");
      step(8'h01, 1, 8'h00, 0, "wrap_r7");
      step(8'h01, 1, 8'h01, 0, "wrap_g0");
      step(8'h00, 1, 8'h00, 0, "wrap_r0");

      // Watchdog eviction 16 cycles after grant
      step(8'h02, 0, 8'h02, 0, "wd_grant");
      for (int k = 1; k <= 15; k++) step(8'h03, 0, 8'h02, 0, "wd_hold");
      step(8'h03, 0, 8'h00, 1, "wd_evict");
      step(8'h03, 0, 8'h01, 0, "wd_next0");
      step(8'h03, 1, 8'h01, 0, "wd_hold0");
      step(8'h02, 1, 8'h00, 0, "wd_rel0");
      step(8'h02, 1, 8'h00, 0, "wd_masked");
      step(8'h00, 1, 8'h00, 0, "wd_unmask");

      // Ready pulse in granted cycle 15 restarts the count
      step(8'h02, 0, 8'h02, 0, "rdy_grant");
      for (int k = 1; k <= 15; k++) step(8'h02, 0, 8'h02, 0, "rdy_hold");
      step(8'h02, 1, 8'h02, 0, "rdy_pulse");
      for (int k = 1; k <= 15; k++) step(8'h02, 0, 8'h02, 0, "rdy_hold2");
      step(8'h02, 0, 8'h00, 1, "rdy_evict");
      step(8'h00, 0, 8'h00, 0, "rdy_clear");

      // Owner drops on the eviction edge: clean release
      step(8'h02, 0, 8'h02, 0, "drop_grant");
      for (int k = 1; k <= 15; k++) step(8'h02, 0, 8'h02, 0, "drop_hold");
      step(8'h00, 0, 8'h00, 0, "drop_edge");
      step(8'h02, 1, 8'h02, 0, "drop_regrant");
      step(8'h02, 1, 8'h02, 0, "drop_hold1");

      // Async reset mid-grant
      #2 Nrst = 1'b0;
      #1;
      m_owner = '0; m_tid = '0;
      exp_q.push_back('0); tag_q.push_back("async_rst");
      compare();
      #1 Nrst = 1'b1;
      step(8'h02, 1, 8'h02, 0, "post_rst_grant");
      step(8'h00, 1, 8'h00, 0, "post_rst_rel");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Sequential round-robin arbiter for the shared OR-combined system bus. Masters are ICache, DCache and future requesters. Replaces fixed-priority combinational arbitration with these features:
- Registered one-hot grants that stay locked for the whole transaction.
- A mandatory dead cycle between owners, so OR-combined addr/data lines drain.
- A watchdog that evicts an owner that stalls the bus.

Sits between the per-master bus_req/bus_ack pairs and the bus slave's bus_ready.

Parameters:
NREQ, 8, number of requester slots; bit index = requester id (0 = ICache, 1 = DCache).
TIMEOUT, 64, consecutive granted cycles without bus_ready before forced eviction; 0 disables the watchdog.
IDW, 3, width of owner/id outputs; must satisfy 2**IDW >= NREQ.

Ports:
clk  input  1  system clock
Nrst  input  1  asynchronous active-low reset
bus_req  input  NREQ  per-requester request, level, held for the whole transaction
bus_ready  input  1  slave beat-complete indication from the bus
bus_ack  output  NREQ  one-hot registered grant; all-zero when bus idle
bus_busy  output  1  high while any grant is held (OR of bus_ack)
bus_owner  output  IDW  id of current grantee; holds last owner when idle
timeout_err  output  1  one-cycle pulse on watchdog eviction
timeout_id  output  IDW  id of evicted requester; valid with timeout_err, held afterwards

Behaviour:
- Async reset (Nrst low) clears immediately, regardless of clock:
  - bus_ack=0, bus_busy=0, bus_owner=0, timeout_err=0, timeout_id=0.
  - Priority pointer=0, mask=0, watchdog count=0, state=IDLE.
- Reset mid-transaction drops the grant at once. Masters must treat loss of ack as abort.
- State IDLE:
  - Eligible set = bus_req & ~mask.
  - If non-empty, pick the first eligible index at or above the pointer, ascending, wrapping modulo NREQ.
  - Next edge: bus_ack = onehot(pick), bus_owner = pick, state → GRANT, count cleared.
  - Latency req→ack is 1 cycle from IDLE.
- State GRANT:
  - bus_ack is held constant. Requests from non-owners are ignored.
  - Owner's bus_req low at an edge → bus_ack=0 next cycle, pointer = owner+1 mod NREQ, state → IDLE.
  - This guarantees at least one all-zero-ack cycle between any two grants, including back-to-back grants to the same master.
- Watchdog (TIMEOUT>0):
  - Count is cleared on entering GRANT and on every GRANT cycle where bus_ready=1.
  - Otherwise it increments while in GRANT, saturating.
  - Eviction fires when count reaches TIMEOUT-1 with bus_ready=0 and owner's req still high.
  - Eviction actions, next edge:
    - bus_ack=0 and state → IDLE.
    - mask[owner] set and pointer = owner+1.
    - timeout_err=1 for exactly one cycle; timeout_id=owner.
- Mask bit i clears on any edge where bus_req[i]=0. An evicted master is re-eligible only after dropping and re-raising req.
- Simultaneous events:
  - Owner req drop on the same edge as eviction → normal release: no error, no mask.
  - bus_ready=1 on the eviction edge → count clears, no eviction.
- Requests at indices ≥ NREQ do not exist. bus_req bits that are X/undriven are a bench error, not handled.
- Counter width = clog2(TIMEOUT+1). The pointer wraps from NREQ-1 to 0.

Decomposition:
- Shared package:
  - Requester id constants (BUS_ICACHE=0, BUS_DCACHE=1, up to BUS_NREQ=8).
  - Arbiter state enum {IDLE, GRANT}.
  - Default TIMEOUT constant.
- One combinational sub-module, rr_pick:
  - Inputs: NREQ-bit vector and pointer.
  - Outputs: valid, index, one-hot.
  - Implementation: double-width rotate-and-priority-encode.
  - Reused later by the writeback/cp arbiters.
- Everything else stays in bus_arbiter_rr.

Test Plan:
- Single requester: reset, raise req[0] at cycle 5, hold 4 cycles with bus_ready=1 → ack[0]=1 cycles 6–9, drops cycle 10, owner=0, busy tracks ack.
- Contention rotation: req=8'b0000_0011 held permanently, each grantee drops req after 3 cycles then re-raises → grants alternate 0,1,0,1 with exactly one ack=0 cycle between each.
- Wrap-around: pointer at 7 after serving id 6, req=8'b1000_0001 → id 7 granted first, then id 0, pointer wraps to 0 then 1.
- Watchdog: TIMEOUT=16, req[1] granted, bus_ready held 0 → eviction edge 16 cycles after grant, timeout_err pulses 1 cycle, timeout_id=1. With req[1] still high and req[0] high, id 0 is granted next and id 1 is not regranted until req[1] toggles low.
- Watchdog boundaries:
  - bus_ready pulse at granted cycle 15 (TIMEOUT=16) → no eviction, count restarts.
  - Owner dropping req on the eviction edge → clean release, timeout_err stays 0.
- Async reset mid-grant: Nrst low between clock edges while ack[1]=1 → bus_ack=0 immediately, before the next clk. After release, req[1] high → ack[1] 1 cycle after first edge with Nrst=1.
